// File: rtl/timer_event_capture.sv
// timer_event_capture: timestamps rising edges of event_in with a free-running
// 32-bit cycle counter and queues them for a 16-bit Avalon-MM reader.
// Optional build macro: CAPTURE_SYNC_EN adds a 2-flop synchronizer on event_in.
module timer_event_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        event_in,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);

  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CNT_MAX = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic [31:0]        tstamp_q, tstamp_d;
  logic               ev, ev_d_q;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [15:0]        shadow_q, shadow_d;
  logic               ovf_q, ovf_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic [15:0]        readdata_q, readdata_d;
  logic [31:0]        mem [FIFO_DEPTH];

  logic        rd_stb, wr_stb, rise, push, pop, push_ok, drop, empty, full;
  logic [31:0] head;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[15:2];

`ifdef CAPTURE_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer for an event source from another clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], event_in};
  end
  assign ev = sync_q[1];
`else
  assign ev = event_in;
`endif

  assign rd_stb = chipselect & ~read_n;
  assign wr_stb = chipselect & ~write_n;
  assign rise   = ev & ~ev_d_q;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_MAX);
  assign head   = empty ? 32'h0 : mem[rd_ptr_q];
  assign push   = rise & ctrl_q[1];
  assign pop    = rd_stb & (address == 3'd3) & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next-state for counter, FIFO bookkeeping, registers and read data.
  always_comb begin
    tstamp_d   = tstamp_q + 32'd1;
    ctrl_d     = ctrl_q;
    shadow_d   = shadow_q;
    ovf_d      = ovf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    readdata_d = readdata_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push_ok) cnt_d = cnt_q - CNT_ONE;

    if (wr_stb && address == 3'd0) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;  // set wins over a simultaneous clear
    if (wr_stb && address == 3'd1) ctrl_d = writedata[1:0];

    if (rd_stb) begin
      case (address)
        3'd0:    readdata_d = {8'(cnt_q), 5'b0, ovf_q, full, ~empty};
        3'd1:    readdata_d = {14'b0, ctrl_q};
        3'd2:    readdata_d = head[15:0];
        3'd3:    readdata_d = head[31:16];
        3'd4:    begin
                   readdata_d = tstamp_q[15:0];
                   shadow_d   = tstamp_q[31:16];
                 end
        3'd5:    readdata_d = shadow_q;
        default: readdata_d = 16'h0;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tstamp_q   <= '0;
      ev_d_q     <= 1'b0;
      ctrl_q     <= '0;
      shadow_q   <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      tstamp_q   <= tstamp_d;
      ev_d_q     <= ev;
      ctrl_q     <= ctrl_d;
      shadow_q   <= shadow_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      readdata_q <= readdata_d;
    end
  end

  // Timestamp storage; contents are meaningless while the slot is not counted.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= tstamp_q;
  end

  assign readdata = readdata_q;
  assign irq      = ctrl_q[0] & ~empty;

endmodule

// File: tb/tb_timer_event_capture.sv
// Bench for timer_event_capture: directed scenarios plus random bus/event traffic
// checked against a queue-based reference model.
module tb_timer_event_capture;

  localparam int DEPTH = 8;
`ifdef CAPTURE_SYNC_EN
  localparam bit SYNC = 1'b1;
  localparam logic [15:0] T1_EXP = 16'h000C;
`else
  localparam bit SYNC = 1'b0;
  localparam logic [15:0] T1_EXP = 16'h000A;
`endif

  logic        clk, reset, event_in, chipselect, read_n, write_n, irq;
  logic [2:0]  address;
  logic [15:0] writedata, readdata;

  timer_event_capture #(.FIFO_DEPTH(DEPTH), .FIFO_AW(3)) dut (
    .clk(clk), .reset(reset), .event_in(event_in), .address(address),
    .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int unsigned q[$];
  int unsigned m_ts;
  bit          m_ovf, m_cap, m_irqen, m_s1, m_s2, m_evp;
  logic [15:0] m_sh, m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; event_in = 1'b0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; address = 3'd0; writedata = 16'h0;
    q.delete(); m_ts = 0; m_ovf = 0; m_cap = 0; m_irqen = 0;
    m_s1 = 0; m_s2 = 0; m_evp = 0; m_sh = 0; m_rd = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
  endtask

  // One clock: drive inputs, advance model, compare after the edge.
  task automatic cycle(input logic ev, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [15:0] wd);
    logic evx, rise;
    logic [15:0] rv;
    int unsigned h;
    event_in = ev; chipselect = rd | wr; read_n = ~rd; write_n = ~wr;
    address = a; writedata = wd;

    evx  = SYNC ? m_s2 : ev;
    rise = evx && !m_evp;
    h    = (q.size() > 0) ? q[0] : 0;
    case (a)
      3'd0: rv = {8'(q.size()), 5'b0, m_ovf, q.size() == DEPTH, q.size() > 0};
      3'd1: rv = {14'b0, m_cap, m_irqen};
      3'd2: rv = h[15:0];
      3'd3: rv = h[31:16];
      3'd4: rv = m_ts[15:0];
      3'd5: rv = m_sh;
      default: rv = 16'h0;
    endcase
    if (rd && a == 3'd3 && q.size() > 0) void'(q.pop_front());
    if (wr && a == 3'd0) m_ovf = 0;
    if (rise && m_cap) begin
      if (q.size() < DEPTH) q.push_back(m_ts);
      else m_ovf = 1;
    end
    if (wr && a == 3'd1) {m_cap, m_irqen} = wd[1:0];
    if (rd && a == 3'd4) m_sh = m_ts[31:16];
    if (rd) m_rd = rv;
    m_ts++;
    m_s2 = m_s1; m_s1 = ev; m_evp = evx;

    @(posedge clk); #1;
    check("irq", irq, m_irqen && q.size() > 0);
    if (rd) check($sformatf("read_a%0d", a), readdata, m_rd);
  endtask

  initial begin
    int unsigned t3, tl;
    logic [15:0] lo, hi;
    do_reset();

    // 1: single capture at tstamp 10
    cycle(0, 0, 1, 3'd1, 16'h3);
    while (m_ts != 10) cycle(0, 0, 0, 3'd0, 0);
    repeat (4) cycle(1, 0, 0, 3'd0, 0);
    cycle(1, 1, 0, 3'd2, 0);
    check("t1_data_l", readdata, T1_EXP);
    check("t1_irq_before", irq, 1);
    cycle(1, 1, 0, 3'd3, 0);
    check("t1_data_h", readdata, 0);
    check("t1_irq_after", irq, 0);

    // 2: overflow after 9 edges
    do_reset();
    cycle(0, 0, 1, 3'd1, 16'h3);
    repeat (9) begin cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); end
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 3'd0, 0);
    check("t2_status_ovf", readdata, 16'h0807);
    cycle(0, 0, 1, 3'd0, 16'h1234);
    cycle(0, 1, 0, 3'd0, 0);
    check("t2_status_clr", readdata, 16'h0803);

    // 3: push and pop together while full
    if (SYNC) begin cycle(1, 0, 0, 0, 0); cycle(1, 0, 0, 0, 0); end
    t3 = m_ts;
    cycle(1, 1, 0, 3'd3, 0);
    cycle(0, 1, 0, 3'd0, 0);
    check("t3_status", readdata, 16'h0803);
    repeat (7) cycle(0, 1, 0, 3'd3, 0);
    cycle(0, 1, 0, 3'd2, 0);
    check("t3_last_l", readdata, t3 & 32'hFFFF);
    cycle(0, 1, 0, 3'd3, 0);
    check("t3_last_h", readdata, t3 >> 16);

    // 5: capture disabled, coherent time read
    do_reset();
    cycle(0, 0, 1, 3'd1, 16'h1);
    repeat (3) begin cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); end
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 3'd0, 0);
    check("t5_status", readdata, 0);
    check("t5_irq", irq, 0);
    tl = m_ts;
    cycle(0, 1, 0, 3'd4, 0);
    lo = readdata;
    cycle(0, 1, 0, 3'd5, 0);
    hi = readdata;
    check("t5_time", {hi, lo}, tl);

    // 6: reset mid-operation
    do_reset();
    cycle(0, 0, 1, 3'd1, 16'h3);
    repeat (2) begin cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0); end
    repeat (3) cycle(0, 0, 0, 0, 0);
    check("t6_irq_pre", irq, 1);
    do_reset();
    cycle(0, 1, 0, 3'd4, 0);
    check("t6_tstamp_restart", readdata, 0);
    cycle(0, 1, 0, 3'd0, 0);
    check("t6_status", readdata, 0);

    // random traffic
    do_reset();
    cycle(0, 0, 1, 3'd1, 16'h3);
    for (int i = 0; i < 4000; i++) begin
      logic ev;
      int op;
      ev = ($urandom_range(0, 3) == 0) ? ~event_in : event_in;
      op = $urandom_range(0, 15);
      if (op < 6)       cycle(ev, 0, 0, 3'd0, 0);
      else if (op < 9)  cycle(ev, 1, 0, 3'($urandom_range(0, 7)), 0);
      else if (op < 12) cycle(ev, 1, 0, 3'd3, 0);
      else if (op < 14) cycle(ev, 0, 1, 3'd0, 16'($urandom()));
      else if (op < 15) cycle(ev, 0, 1, 3'd1, ($urandom_range(0, 7) == 0) ? 16'h1 : 16'h3);
      else              cycle(ev, 0, 1, 3'($urandom_range(2, 7)), 16'($urandom()));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
